// File: rtl/seg_scan4.sv
// Four-digit multiplexed BCD display scanner with frame-synchronous value update,
// optional leading-zero blanking and a per-slot dead time before each digit enable.
module seg_scan4 #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 2,
  parameter int LZB      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] bcd_in,
  output logic [3:0]  src_num,
  output logic [3:0]  dig_sel,
  output logic        load_pend,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_C = CW'(DEAD);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    dig_idx_q, dig_idx_d;
  logic [15:0]   pend_q, pend_d;
  logic [15:0]   disp_q, disp_d;
  logic          load_pend_q, load_pend_d;
  logic          frame_done_q, frame_done_d;
  logic          tick, wrap;
  logic [15:0]   upper;
  logic          blank;

  assign tick = (div_cnt_q == LAST);
  assign wrap = tick && (dig_idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      dig_idx_q    <= '0;
      pend_q       <= '0;
      disp_q       <= '1;
      load_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      dig_idx_q    <= dig_idx_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      load_pend_q  <= load_pend_d;
      frame_done_q <= frame_done_d;
    end
  end

  // A load on the wrap tick bypasses the pending register and is shown at once.
  always_comb begin
    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    dig_idx_d    = tick ? dig_idx_q + 2'd1 : dig_idx_q;
    pend_d       = load ? bcd_in : pend_q;
    disp_d       = disp_q;
    load_pend_d  = load_pend_q;
    frame_done_d = wrap;
    if (wrap) begin
      load_pend_d = 1'b0;
      if (load)
        disp_d = bcd_in;
      else if (load_pend_q)
        disp_d = pend_q;
    end else if (load) begin
      load_pend_d = 1'b1;
    end
  end

  // Digit k is blanked when it and every more significant digit are zero.
  always_comb begin
    upper   = disp_q >> {dig_idx_q, 2'b00};
    blank   = (LZB != 0) && (dig_idx_q != 2'd0) && (upper == 16'h0000);
    src_num = blank ? 4'hF : upper[3:0];
    if (div_cnt_q < DEAD_C)
      dig_sel = '1;
    else
      dig_sel = ~(4'b0001 << dig_idx_q);
  end

  assign load_pend  = load_pend_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan4.sv
// Bench for seg_scan4 with SCAN_DIV=4, DEAD=1: one instance with blanking, one without,
// checked every cycle against a time-based model plus literal spot checks.
module tb_seg_scan4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  src1, sel1, src0, sel0;
  logic        lp1, fd1, lp0, fd0;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  seg_scan4 #(.SCAN_DIV(4), .DEAD(1), .LZB(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in),
    .src_num(src1), .dig_sel(sel1), .load_pend(lp1), .frame_done(fd1)
  );

  seg_scan4 #(.SCAN_DIV(4), .DEAD(1), .LZB(0)) dut_nolzb (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in),
    .src_num(src0), .dig_sel(sel0), .load_pend(lp0), .frame_done(fd0)
  );

  // Model: m_t = rising edges since reset release; frame = 16 cycles, slot = 4 cycles.
  int          m_t = 0;
  logic [15:0] m_disp = 16'hFFFF;
  logic [15:0] m_pval = 16'h0000;
  bit          m_pend = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_disp = 16'hFFFF; m_pval = 16'h0000; m_pend = 1'b0;
    end else begin
      if (m_t % 16 == 15) begin
        if (load) m_disp = bcd_in;
        else if (m_pend) m_disp = m_pval;
        m_pend = 1'b0;
      end else if (load) begin
        m_pval = bcd_in;
        m_pend = 1'b1;
      end
      m_t++;
    end
  end

  function automatic logic [3:0] exp_src(input logic [15:0] d, input int slot, input bit lzb);
    logic [15:0] s;
    s = d >> (4 * slot);
    if (lzb && slot > 0 && s == 16'h0000) return 4'hF;
    return s[3:0];
  endfunction

  function automatic logic [3:0] exp_sel(input int t);
    logic [3:0] one;
    one = 4'b0001;
    if (t % 4 < 1) return 4'b1111;
    return ~(one << ((t / 4) % 4));
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%h exp=%h", nm, m_t, got, exp);
  endtask

  always @(negedge clk) begin
    int slot;
    slot = (m_t / 4) % 4;
    chk("u1_src", 16'(src1), 16'(exp_src(m_disp, slot, 1'b1)));
    chk("u1_sel", 16'(sel1), 16'(exp_sel(m_t)));
    chk("u1_lp",  16'(lp1),  16'(m_pend));
    chk("u1_fd",  16'(fd1),  16'((m_t % 16 == 0) && (m_t != 0)));
    chk("u0_src", 16'(src0), 16'(exp_src(m_disp, slot, 1'b0)));
    chk("u0_sel", 16'(sel0), 16'(exp_sel(m_t)));
    chk("u0_lp",  16'(lp0),  16'(m_pend));
    chk("u0_fd",  16'(fd0),  16'((m_t % 16 == 0) && (m_t != 0)));
  end

  task automatic goto(input int target);
    while (m_t < target) @(negedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input int at);
    goto(at);
    load = 1'b1; bcd_in = v;
    goto(at + 1);
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d got=timeout exp=finish", m_t);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v1234 [4];
    v1234 = '{4'h4, 4'h3, 4'h2, 4'h1};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_src", 16'(src1), 16'hF);
    chk("rst_sel", 16'(sel1), 16'hF);
    chk("rst_lp", 16'(lp1), 16'h0);
    chk("rst_fd", 16'(fd1), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1234 loaded at cycle 2, shown from the next frame
    do_load(16'h1234, 2);
    chk("lit_lp_1234", 16'(lp1), 16'h1);
    goto(16);
    chk("lit_fd16", 16'(fd1), 16'h1);
    chk("lit_lp_clr", 16'(lp1), 16'h0);
    chk("lit_dead16", 16'(sel1), 16'hF);
    for (int k = 0; k < 4; k++) begin
      goto(17 + 4 * k);
      chk("lit_src1234", 16'(src1), 16'(v1234[k]));
    end
    chk("lit_sel29", 16'(sel1), 16'b0111);

    do_load(16'h0007, 30);
    goto(33); chk("lit_0007_d0", 16'(src1), 16'h7);
    goto(37); chk("lit_0007_d1", 16'(src1), 16'hF);
              chk("lit_0007_nolzb", 16'(src0), 16'h0);
    goto(45); chk("lit_0007_d3", 16'(src1), 16'hF);

    do_load(16'h0000, 46);
    goto(49); chk("lit_0000_d0", 16'(src1), 16'h0);
    goto(53); chk("lit_0000_d1", 16'(src1), 16'hF);

    do_load(16'h0050, 62);
    goto(65); chk("lit_0050_d0", 16'(src0), 16'h0);
    goto(69); chk("lit_0050_d1", 16'(src0), 16'h5);
    goto(73); chk("lit_0050_d2", 16'(src0), 16'h0);
              chk("lit_0050_lzb_d2", 16'(src1), 16'hF);
    goto(77); chk("lit_0050_d3", 16'(src0), 16'h0);

    do_load(16'h1111, 82);
    do_load(16'h2222, 86);
    for (int k = 0; k < 4; k++) begin
      goto(97 + 4 * k);
      chk("lit_2222", 16'(src1), 16'h2);
    end

    do_load(16'h9999, 111);
    chk("lit_9999_lp", 16'(lp1), 16'h0);
    goto(113); chk("lit_9999_d0", 16'(src1), 16'h9);

    do_load(16'hABCD, 114);
    goto(129); chk("lit_abcd_d0", 16'(src1), 16'hD);
    goto(141); chk("lit_abcd_d3", 16'(src1), 16'hA);
    goto(144); chk("lit_fd144", 16'(fd1), 16'h1);

    // pending load discarded by a mid-frame reset
    do_load(16'h5555, 150);
    chk("lit_lp_5555", 16'(lp1), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_mrst_src", 16'(src1), 16'hF);
    chk("lit_mrst_sel", 16'(sel1), 16'hF);
    chk("lit_mrst_lp", 16'(lp1), 16'h0);
    chk("lit_mrst_fd", 16'(fd1), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto(17); chk("lit_post_rst_src", 16'(src1), 16'hF);
    goto(36);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
